// File: rtl/alu_ctrl.sv
// Sequencer that feeds operands to an external two-register ALU and collects its result.
// Optional operand bypass (skip reloading unchanged ALU registers): define ALU_CTRL_BYPASS_EN.
module alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_shift,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_carry,
    output logic             rega_write_enable,
    output logic             regb_write_enable,
    output logic             alu_enable,
    output logic             mul_enable,
    output logic             sub_enable,
    output logic             shift_enable,
    output logic [2:0]       shift_pos,
    output logic [WIDTH-1:0] alu_bus_in,
    input  logic [WIDTH-1:0] alu_bus_out,
    input  logic             alu_carry
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_A = 3'd1;
    localparam logic [2:0] LOAD_B = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] READ   = 3'd4;
    localparam logic [2:0] RESP   = 3'd5;

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    logic [2:0]       state_q, state_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       shift_q;
    logic [WIDTH-1:0] resp_data_q;
    logic             resp_carry_q;

    logic need_a_req, need_b_req, need_b_lat;

`ifdef ALU_CTRL_BYPASS_EN
    logic [WIDTH-1:0] shadow_a_q, shadow_b_q;
    logic             shadow_a_vld_q, shadow_b_vld_q;

    // Shadows mirror what the ALU registers hold, so an equal operand needs no reload.
    assign need_a_req = !(shadow_a_vld_q && (shadow_a_q == req_a));
    assign need_b_req = !req_op[1] && !(shadow_b_vld_q && (shadow_b_q == req_b));
    assign need_b_lat = !op_q[1] && !(shadow_b_vld_q && (shadow_b_q == b_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_a_q     <= '0;
            shadow_b_q     <= '0;
            shadow_a_vld_q <= 1'b0;
            shadow_b_vld_q <= 1'b0;
        end else begin
            if (state_q == LOAD_A) begin
                shadow_a_q     <= a_q;
                shadow_a_vld_q <= 1'b1;
            end
            if (state_q == LOAD_B) begin
                shadow_b_q     <= b_q;
                shadow_b_vld_q <= 1'b1;
            end
        end
    end
`else
    assign need_a_req = 1'b1;
    assign need_b_req = !req_op[1];
    assign need_b_lat = !op_q[1];
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (need_a_req)      state_d = LOAD_A;
                    else if (need_b_req) state_d = LOAD_B;
                    else                 state_d = EXEC;
                end
            end
            LOAD_A:  state_d = need_b_lat ? LOAD_B : EXEC;
            LOAD_B:  state_d = EXEC;
            EXEC:    state_d = READ;
            READ:    state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rega_write_enable = 1'b0;
        regb_write_enable = 1'b0;
        alu_enable        = 1'b0;
        mul_enable        = 1'b0;
        sub_enable        = 1'b0;
        shift_enable      = 1'b0;
        shift_pos         = '0;
        alu_bus_in        = '0;
        case (state_q)
            LOAD_A: begin
                rega_write_enable = 1'b1;
                alu_bus_in        = a_q;
            end
            LOAD_B: begin
                regb_write_enable = 1'b1;
                alu_bus_in        = b_q;
            end
            EXEC, READ: begin
                // Op controls stay identical across EXEC and READ so the ALU result settles.
                mul_enable   = (op_q == OP_MUL);
                sub_enable   = (op_q == OP_SUB);
                shift_enable = (op_q == OP_SHL);
                shift_pos    = shift_q;
                alu_enable   = (state_q == READ);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            shift_q      <= '0;
            resp_data_q  <= '0;
            resp_carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                op_q    <= req_op;
                a_q     <= req_a;
                b_q     <= req_b;
                shift_q <= req_shift;
            end
            if (state_q == READ) begin
                resp_data_q  <= alu_bus_out;
                resp_carry_q <= alu_carry;
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_data  = resp_data_q;
    assign resp_carry = resp_carry_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural two-register ALU and a response scoreboard.
// Build with ALU_CTRL_BYPASS_EN defined to also cover the operand-bypass path.
module tb_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready;
    logic [1:0] req_op;
    logic [7:0] req_a, req_b;
    logic [2:0] req_shift;
    logic       resp_valid, resp_ready;
    logic [7:0] resp_data;
    logic       resp_carry;
    logic       rega_write_enable, regb_write_enable, alu_enable;
    logic       mul_enable, sub_enable, shift_enable;
    logic [2:0] shift_pos;
    logic [7:0] alu_bus_in, alu_bus_out;
    logic       alu_carry;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       carry;
        int         lat;
    } exp_t;
    exp_t sb[$];

    alu_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_shift(req_shift),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_carry(resp_carry),
        .rega_write_enable(rega_write_enable), .regb_write_enable(regb_write_enable),
        .alu_enable(alu_enable), .mul_enable(mul_enable), .sub_enable(sub_enable),
        .shift_enable(shift_enable), .shift_pos(shift_pos), .alu_bus_in(alu_bus_in),
        .alu_bus_out(alu_bus_out), .alu_carry(alu_carry)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: mul is the product of the two nibbles of reg_a.
    logic [7:0] reg_a = 8'h00, reg_b = 8'h00;
    logic [8:0] res;
    always @(posedge clk) begin
        if (rega_write_enable) reg_a <= alu_bus_in;
        if (regb_write_enable) reg_b <= alu_bus_in;
    end
    always_comb begin
        res = '0;
        if (mul_enable)        res = 9'(reg_a[7:4]) * 9'(reg_a[3:0]);
        else if (shift_enable) res = {1'b0, reg_a} << shift_pos;
        else if (sub_enable)   res = {1'b0, reg_a} + {1'b0, ~reg_b} + 9'd1;
        else                   res = {1'b0, reg_a} + {1'b0, reg_b};
        alu_bus_out = alu_enable ? res[7:0] : 8'h00;
        alu_carry   = alu_enable ? res[8] : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_side();
        return {16'h0, alu_bus_in, rega_write_enable, regb_write_enable, alu_enable,
                mul_enable, sub_enable, shift_enable, shift_pos == 3'd0 ? 2'b00 : 2'b11};
    endfunction

    // Issue one request, wait for its response, optionally hold resp_ready low for bp cycles.
    task automatic send(input string tag, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] sh, input logic [7:0] ed,
                        input logic ec, input int elat, input int bp, input int exp_bwe,
                        input int exp_any_we);
        exp_t e;
        exp_t got;
        int   lat;
        bit   both_we, b_we, any_we, stable;
        e.data = ed; e.carry = ec; e.lat = elat;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_shift = sh;
        resp_ready = (bp == 0);
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        sb.push_back(e);
        @(posedge clk); #1;
        // Changes after acceptance must be ignored.
        req_valid = 1'b0; req_a = ~a; req_b = ~b; req_op = ~op; req_shift = ~sh;
        lat = 1; both_we = 0; b_we = 0; any_we = 0;
        while (!resp_valid && lat < 20) begin
            if (rega_write_enable && regb_write_enable) both_we = 1;
            if (regb_write_enable) b_we = 1;
            if (rega_write_enable || regb_write_enable) any_we = 1;
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid) begin
            check({tag, ".timeout"}, 32'(resp_valid), 32'd1);
            void'(sb.pop_front());
            return;
        end
        got = sb.pop_front();
        check({tag, ".latency"}, 32'(lat), 32'(got.lat));
        check({tag, ".data"}, 32'(resp_data), 32'(got.data));
        check({tag, ".carry"}, 32'(resp_carry), 32'(got.carry));
        check({tag, ".both_we"}, 32'(both_we), 32'd0);
        check({tag, ".alu_idle_in_resp"}, alu_side(), 32'd0);
        if (exp_bwe >= 0) check({tag, ".regb_we_seen"}, 32'(b_we), 32'(exp_bwe));
        if (exp_any_we >= 0) check({tag, ".any_we_seen"}, 32'(any_we), 32'(exp_any_we));
        if (bp > 0) begin
            stable = 1;
            for (int i = 0; i < bp; i++) begin
                @(posedge clk); #1;
                if (!resp_valid || resp_data !== got.data || req_ready) stable = 0;
            end
            check({tag, ".backpressure_stable"}, 32'(stable), 32'd1);
            resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, ".idle_after"}, {30'd0, req_ready, resp_valid}, 32'b10);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_shift = '0;
        resp_ready = 1'b1;
        #1;
        check("reset.resp", {22'd0, resp_valid, resp_carry, resp_data}, 32'd0);
        check("reset.alu_side", alu_side(), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset.req_ready", 32'(req_ready), 32'd1);

        send("add", 2'b00, 8'hF0, 8'h20, 3'd0, 8'h10, 1'b1, 5, 0, 1, -1);
        send("sub", 2'b01, 8'h05, 8'h07, 3'd0, 8'hFE, 1'b0, 5, 0, 1, -1);
        send("mul", 2'b11, 8'h34, 8'h99, 3'd0, 8'h0C, 1'b0, 4, 0, 0, -1);
        send("shl", 2'b10, 8'h81, 8'h00, 3'd1, 8'h02, 1'b1, 4, 0, 0, -1);
        send("bp",  2'b00, 8'h40, 8'h3F, 3'd0, 8'h7F, 1'b0, 5, 10, 1, -1);

        // Reset in the middle of a subtract while it sits in EXEC.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_a = 8'h55; req_b = 8'h66;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        check("rst_exec.pre_sub_enable", 32'(sub_enable), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_exec.resp", {22'd0, resp_valid, resp_carry, resp_data}, 32'd0);
        check("rst_exec.alu_side", alu_side(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_exec.req_ready", 32'(req_ready), 32'd1);
        send("post_rst_add", 2'b00, 8'h01, 8'h01, 3'd0, 8'h02, 1'b0, 5, 0, 1, -1);

`ifdef ALU_CTRL_BYPASS_EN
        send("byp_first", 2'b00, 8'h11, 8'h22, 3'd0, 8'h33, 1'b0, 5, 0, 1, 1);
        send("byp_second", 2'b00, 8'h11, 8'h22, 3'd0, 8'h33, 1'b0, 3, 0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
